mm_refill_ctrl: RTL and testbench

Miss-refill controller that sits directly downstream of the direct-mapped instruction cache. It watches the cache's HitWrite (0 = miss), fetches the missing word from main memory over a req/ready handshake, and returns it to the cache as a one-cycle Access_MM fill pulse with Data_MM and index. It enforces a minimum miss penalty, drives the pipeline stall, and keeps penalty and fill counters for performance checks.

---
 rtl/mm_refill_ctrl_if.sv | 26 ++
 rtl/mm_refill_ctrl.sv | 86 ++++++++
 tb/tb_mm_refill_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_refill_ctrl_if.sv
// Cache-side, memory-side and counter signals of the instruction-cache miss-refill controller.
// The slave modport is the controller view and the master modport is the cache/memory view.
interface mm_refill_ctrl_if;
    logic [31:0] PC;
    logic        HitWrite;
    logic [31:0] MM_Rdata;
    logic        MM_Ready;
    logic        MM_Req;
    logic [31:0] MM_Addr;
    logic        Access_MM;
    logic [31:0] Data_MM;
    logic [2:0]  index;
    logic        Stall;
    logic [19:0] CNT_PENALTY;
    logic [19:0] CNT_FILL;

    modport slave (
        input  PC, HitWrite, MM_Rdata, MM_Ready,
        output MM_Req, MM_Addr, Access_MM, Data_MM, index, Stall, CNT_PENALTY, CNT_FILL
    );

    modport master (
        output PC, HitWrite, MM_Rdata, MM_Ready,
        input  MM_Req, MM_Addr, Access_MM, Data_MM, index, Stall, CNT_PENALTY, CNT_FILL
    );
endinterface

// File: rtl/mm_refill_ctrl.sv
// Instruction-cache miss refill: one memory read per miss, one-cycle fill strobe, pipeline stall.
// Stall lasts max(MISS_PENALTY, ready latency)+1 cycles; MM_Req is held until the read word is taken.
module mm_refill_ctrl #(
    parameter int unsigned MISS_PENALTY = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    mm_refill_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    localparam logic [7:0] WCNT_LAST = 8'(MISS_PENALTY - 1);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        got_q, got_d;
    logic [31:0] data_q, data_d;
    logic [31:2] addr_q, addr_d;
    logic [19:0] cnt_pen_q, cnt_pen_d;
    logic [19:0] cnt_fill_q, cnt_fill_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            got_q      <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            cnt_pen_q  <= '0;
            cnt_fill_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            got_q      <= got_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            cnt_pen_q  <= cnt_pen_d;
            cnt_fill_q <= cnt_fill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        got_d      = got_q;
        data_d     = data_q;
        addr_d     = addr_q;
        cnt_pen_d  = cnt_pen_q;
        cnt_fill_d = cnt_fill_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.HitWrite) begin
                    state_d = S_REQ;
                    addr_d  = bus.PC[31:2];
                    wcnt_d  = '0;
                    got_d   = 1'b0;
                end
            end
            S_REQ: begin
                // Saturate so very slow memory cannot wrap below the penalty threshold.
                if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
                if (bus.MM_Ready && !got_q) begin
                    data_d = bus.MM_Rdata;
                    got_d  = 1'b1;
                end
                if ((got_q || bus.MM_Ready) && (wcnt_q >= WCNT_LAST)) state_d = S_FILL;
            end
            S_FILL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && cnt_pen_q != 20'hFFFFF) cnt_pen_d = cnt_pen_q + 20'd1;
        if (state_q == S_FILL && cnt_fill_q != 20'hFFFFF) cnt_fill_d = cnt_fill_q + 20'd1;
    end

    always_comb begin
        bus.MM_Req      = (state_q == S_REQ);
        bus.Access_MM   = (state_q == S_FILL);
        bus.Stall       = (state_q != S_IDLE);
        bus.MM_Addr     = {addr_q, 2'b00};
        bus.Data_MM     = data_q;
        // In IDLE the cache indexes with the live PC; during a miss it sees the latched line.
        bus.index       = (state_q == S_IDLE) ? bus.PC[4:2] : addr_q[4:2];
        bus.CNT_PENALTY = cnt_pen_q;
        bus.CNT_FILL    = cnt_fill_q;
    end
endmodule

// File: tb/tb_mm_refill_ctrl.sv
// Directed bench for mm_refill_ctrl: penalty 4 and penalty 6 instances share one stimulus set.
module tb_mm_refill_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] rdata = '0;
    logic        hitw = 1'b1;
    logic        ready = 1'b0;
    bit          sel = 1'b0;

    int total = 0;
    int bad = 0;

    mm_refill_ctrl_if ifa();
    mm_refill_ctrl_if ifb();

    assign ifa.PC = pc;
    assign ifa.HitWrite = hitw;
    assign ifa.MM_Rdata = rdata;
    assign ifa.MM_Ready = ready;
    assign ifb.PC = pc;
    assign ifb.HitWrite = hitw;
    assign ifb.MM_Rdata = rdata;
    assign ifb.MM_Ready = ready;

    mm_refill_ctrl #(.MISS_PENALTY(4)) dut4 (.CLK(CLK), .RESET(RESET), .bus(ifa.slave));
    mm_refill_ctrl #(.MISS_PENALTY(6)) dut6 (.CLK(CLK), .RESET(RESET), .bus(ifb.slave));

    logic        o_req, o_acc, o_stall;
    logic [31:0] o_addr, o_data;
    logic [2:0]  o_idx;
    logic [19:0] o_cp, o_cf;

    always_comb begin
        o_req   = sel ? ifb.MM_Req      : ifa.MM_Req;
        o_acc   = sel ? ifb.Access_MM   : ifa.Access_MM;
        o_stall = sel ? ifb.Stall       : ifa.Stall;
        o_addr  = sel ? ifb.MM_Addr     : ifa.MM_Addr;
        o_data  = sel ? ifb.Data_MM     : ifa.Data_MM;
        o_idx   = sel ? ifb.index       : ifa.index;
        o_cp    = sel ? ifb.CNT_PENALTY : ifa.CNT_PENALTY;
        o_cf    = sel ? ifb.CNT_FILL    : ifa.CNT_FILL;
    end

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one miss at address a; memory strobes in REQ cycles k1 (data d1) and k2 (data d2).
    task automatic do_miss(input logic [31:0] a, input int k1, input logic [31:0] d1,
                           input int k2, input logic [31:0] d2, input bit toggle_pc,
                           output int stalls, output int reqs, output int accs,
                           output logic [31:0] fdata, output logic [2:0] fidx, output int addr_bad);
        int cyc;
        stalls = 0; reqs = 0; accs = 0; fdata = '0; fidx = '0; addr_bad = 0;
        pc = a; hitw = 1'b0; ready = 1'b0;
        step();
        cyc = 1;
        while (o_stall && cyc < 400) begin
            stalls++;
            if (o_req) begin
                reqs++;
                if (o_addr !== {a[31:2], 2'b00}) addr_bad++;
            end
            if (o_acc) begin
                accs++;
                fdata = o_data;
                fidx = o_idx;
                hitw = 1'b1;
            end
            if (o_idx !== a[4:2]) addr_bad++;
            ready = (cyc == k1) || (cyc == k2);
            rdata = (cyc == k1) ? d1 : d2;
            if (toggle_pc) pc = pc ^ 32'h0000_001C;
            step();
            cyc++;
        end
        chk("miss_timeout", 32'(cyc >= 400), 32'd0);
        ready = 1'b0;
        hitw = 1'b1;
        pc = a;
    endtask

    int s, r, n, ab;
    logic [31:0] fd;
    logic [2:0] fi;

    initial begin
        // Reset held with hostile inputs.
        RESET = 1'b0; pc = 32'h0000_0018; hitw = 1'b0; ready = 1'b1; rdata = $urandom;
        repeat (2) step();
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_acc", 32'(o_acc), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_cp", 32'(o_cp), 32'd0);
        chk("rst_cf", 32'(o_cf), 32'd0);
        chk("rst_idx", 32'(o_idx), 32'd6);
        hitw = 1'b1; ready = 1'b0;
        RESET = 1'b1;
        step();
        chk("rel_req", 32'(o_req), 32'd0);
        chk("rel_stall", 32'(o_stall), 32'd0);
        repeat (2) step();

        // Single miss, ready in REQ cycle 2.
        do_miss(32'h0000_0044, 2, 32'hDEADBEEF, 0, 32'h0, 1'b0, s, r, n, fd, fi, ab);
        chk("t1_stall", 32'(s), 32'd5);
        chk("t1_req", 32'(r), 32'd4);
        chk("t1_acc", 32'(n), 32'd1);
        chk("t1_data", fd, 32'hDEADBEEF);
        chk("t1_idx", 32'(fi), 32'd1);
        chk("t1_addr", 32'(ab), 32'd0);
        chk("t1_cp", 32'(o_cp), 32'd5);
        chk("t1_cf", 32'(o_cf), 32'd1);
        repeat (10) step();

        // Slow memory, PC toggling during the stall.
        do_miss(32'h0000_1238, 9, 32'hCAFEF00D, 0, 32'h0, 1'b1, s, r, n, fd, fi, ab);
        chk("t2_stall", 32'(s), 32'd10);
        chk("t2_req", 32'(r), 32'd9);
        chk("t2_acc", 32'(n), 32'd1);
        chk("t2_data", fd, 32'hCAFEF00D);
        chk("t2_idx", 32'(fi), 32'd6);
        chk("t2_addr", 32'(ab), 32'd0);
        chk("t2_cp", 32'(o_cp), 32'd15);
        chk("t2_cf", 32'(o_cf), 32'd2);
        repeat (10) step();

        // Penalty counter saturation.
        force dut4.cnt_pen_q = 20'hFFFFB;
        step();
        release dut4.cnt_pen_q;
        chk("sat_pre", 32'(o_cp), 32'h000F_FFFB);
        do_miss(32'h0000_0080, 1, 32'h0BADF00D, 0, 32'h0, 1'b0, s, r, n, fd, fi, ab);
        chk("sat_stall", 32'(s), 32'd5);
        chk("sat_cp", 32'(o_cp), 32'h000F_FFFF);
        chk("sat_cf", 32'(o_cf), 32'd3);
        repeat (10) step();

        // Penalty 6: early strobe kept, second strobe ignored.
        sel = 1'b1;
        do_miss(32'h0000_0104, 1, 32'h1111_1111, 3, 32'h2222_2222, 1'b0, s, r, n, fd, fi, ab);
        chk("t3_stall", 32'(s), 32'd7);
        chk("t3_req", 32'(r), 32'd6);
        chk("t3_acc", 32'(n), 32'd1);
        chk("t3_data", fd, 32'h1111_1111);
        chk("t3_idx", 32'(fi), 32'd1);
        chk("t3_addr", 32'(ab), 32'd0);
        sel = 1'b0;
        repeat (10) step();

        // Reset in REQ cycle 2, then a late memory strobe.
        pc = 32'h0000_0040; hitw = 1'b0;
        step();
        step();
        chk("mr_inreq", 32'(o_req), 32'd1);
        hitw = 1'b1;
        RESET = 1'b0;
        #1;
        chk("mr_req", 32'(o_req), 32'd0);
        chk("mr_stall", 32'(o_stall), 32'd0);
        chk("mr_acc", 32'(o_acc), 32'd0);
        chk("mr_cp", 32'(o_cp), 32'd0);
        chk("mr_cf", 32'(o_cf), 32'd0);
        chk("mr_addr", o_addr, 32'd0);
        pc = 32'h0000_005C;
        #1;
        chk("mr_idx", 32'(o_idx), 32'd7);
        step();
        RESET = 1'b1; ready = 1'b1; rdata = 32'hBAD0BAD0;
        step();
        ready = 1'b0;
        n = 0; s = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_acc) n++;
            if (o_stall) s++;
            step();
        end
        chk("late_acc", 32'(n), 32'd0);
        chk("late_stall", 32'(s), 32'd0);

        do_miss(32'h0000_0044, 2, 32'h5A5A_A5A5, 0, 32'h0, 1'b0, s, r, n, fd, fi, ab);
        chk("t4_stall", 32'(s), 32'd5);
        chk("t4_data", fd, 32'h5A5A_A5A5);
        chk("t4_cp", 32'(o_cp), 32'd5);
        chk("t4_cf", 32'(o_cf), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
